// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
//   Shares one port of a dual-port block RAM between three requesters:
//   video fetch (0), CPU (1) and disk/DMA (2). The arbiter accepts at most one
//   access per clock, registers the winning command onto the RAM port, and
//   returns read data two cycles after the grant with a one-hot valid strobe.
//   Video wins by fixed priority. Requesters 1 and 2 each have a wait counter
//   that forces a grant after MAX_WAIT cycles (MAX_WAIT must be 1..15).
//
// Ports
//   clk       single clock for all logic and the RAM port
//   reset     synchronous, active-high
//   req/we    per-requester request and write enable (bit i = requester i)
//   addr/din  packed per-requester address / write data
//   gnt       one-hot combinational acceptance, same cycle as req
//   rvalid    one-hot read-data-valid strobe
//   rdata     read data, meaningful while any rvalid bit is set
//   ram_*     registered RAM command; ram_dout is valid one cycle later
module dpram_port_arbiter #(
  parameter int unsigned DATA     = 8,
  parameter int unsigned ADDR     = 14,
  parameter int unsigned MAX_WAIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [3*ADDR-1:0] addr,
  input  logic [3*DATA-1:0] din,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DATA-1:0]   rdata,
  output logic              ram_ce,
  output logic              ram_wr,
  output logic [ADDR-1:0]   ram_addr,
  output logic [DATA-1:0]   ram_din,
  input  logic [DATA-1:0]   ram_dout
);

  typedef enum logic {
    RR_REQ1 = 1'b0,
    RR_REQ2 = 1'b1
  } rr_t;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  rr_t             rr;
  logic [3:0]      w1;
  logic [3:0]      w2;
  logic            starve1;
  logic            starve2;

  logic [1:0]      sel;
  logic            sel_we;
  logic [ADDR-1:0] sel_addr;
  logic [DATA-1:0] sel_din;

  // Stage 1 travels with the command on the RAM port, stage 2 with ram_dout.
  logic [1:0]      tag1;
  logic            tag1_rd;
  logic [1:0]      tag2;
  logic            tag2_rd;

  assign starve1 = req[1] && (w1 == WAIT_LIM);
  assign starve2 = req[2] && (w2 == WAIT_LIM);

  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (starve1 && starve2) begin
        gnt = (rr == RR_REQ1) ? 3'b010 : 3'b100;
      end else if (starve1) begin
        gnt = 3'b010;
      end else if (starve2) begin
        gnt = 3'b100;
      end else if (req[0]) begin
        gnt = 3'b001;
      end else if (req[1] && req[2]) begin
        gnt = (rr == RR_REQ1) ? 3'b010 : 3'b100;
      end else if (req[1]) begin
        gnt = 3'b010;
      end else if (req[2]) begin
        gnt = 3'b100;
      end
    end
  end

  always_comb begin
    sel = 2'd0;
    if (gnt[1]) begin
      sel = 2'd1;
    end else if (gnt[2]) begin
      sel = 2'd2;
    end
  end

  always_comb begin
    sel_we   = we[0];
    sel_addr = addr[0 +: ADDR];
    sel_din  = din[0 +: DATA];
    case (sel)
      2'd1: begin
        sel_we   = we[1];
        sel_addr = addr[ADDR +: ADDR];
        sel_din  = din[DATA +: DATA];
      end
      2'd2: begin
        sel_we   = we[2];
        sel_addr = addr[2*ADDR +: ADDR];
        sel_din  = din[2*DATA +: DATA];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_ce   <= 1'b0;
      ram_wr   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      tag1     <= '0;
      tag1_rd  <= 1'b0;
      tag2     <= '0;
      tag2_rd  <= 1'b0;
      rr       <= RR_REQ1;
      w1       <= '0;
      w2       <= '0;
    end else begin
      ram_ce  <= |gnt;
      ram_wr  <= (|gnt) & sel_we;
      // Address and data hold on idle cycles so the RAM pins stay quiet.
      if (|gnt) begin
        ram_addr <= sel_addr;
        ram_din  <= sel_din;
      end
      tag1    <= sel;
      tag1_rd <= (|gnt) & ~sel_we;
      tag2    <= tag1;
      tag2_rd <= tag1_rd;

      if (gnt[1]) begin
        rr <= RR_REQ2;
      end else if (gnt[2]) begin
        rr <= RR_REQ1;
      end

      if (gnt[1] || !req[1]) begin
        w1 <= '0;
      end else if (w1 < WAIT_LIM) begin
        w1 <= w1 + 4'd1;
      end

      if (gnt[2] || !req[2]) begin
        w2 <= '0;
      end else if (w2 < WAIT_LIM) begin
        w2 <= w2 + 4'd1;
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (tag2_rd) begin
      case (tag2)
        2'd0:    rvalid = 3'b001;
        2'd1:    rvalid = 3'b010;
        2'd2:    rvalid = 3'b100;
        default: rvalid = '0;
      endcase
    end
  end

  assign rdata = ram_dout;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Scoreboard bench for dpram_port_arbiter with a behavioural write-through RAM.
module tb_dpram_port_arbiter;
  localparam int unsigned DATA     = 8;
  localparam int unsigned ADDR     = 14;
  localparam int unsigned MAX_WAIT = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        req;
  logic [2:0]        we;
  logic [3*ADDR-1:0] addr;
  logic [3*DATA-1:0] din;
  logic [2:0]        gnt;
  logic [2:0]        rvalid;
  logic [DATA-1:0]   rdata;
  logic              ram_ce;
  logic              ram_wr;
  logic [ADDR-1:0]   ram_addr;
  logic [DATA-1:0]   ram_din;
  logic [DATA-1:0]   ram_dout;

  dpram_port_arbiter #(
    .DATA(DATA),
    .ADDR(ADDR),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .we(we),
    .addr(addr),
    .din(din),
    .gnt(gnt),
    .rvalid(rvalid),
    .rdata(rdata),
    .ram_ce(ram_ce),
    .ram_wr(ram_wr),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM port model: registered read, write-through.
  logic [DATA-1:0] mem [0:(1<<ADDR)-1];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wr) begin
        mem[ram_addr] = ram_din;
        ram_dout <= ram_din;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  v;
    logic [7:0]  d;
    int unsigned c;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge with inputs already applied for this cycle.
  task automatic tick(input logic [2:0] eg, input logic [7:0] ed, input string name);
    exp_t e;
    #1;
    chk(name, 32'(gnt), 32'(eg));
    if ((eg & ~we) != 3'b000) begin
      e.v = eg;
      e.d = ed;
      e.c = cyc + 2;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 3'b000;
    we  = 3'b000;
    for (int i = 0; i < n; i++) tick(3'b000, 8'h00, "idle_gnt");
  endtask

  // Monitor: every rvalid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (rvalid != 3'b000) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rvalid_unexpected: got rvalid=%b rdata=%h, required no rvalid (cycle %0d)",
                 rvalid, rdata, cyc);
      end else begin
        got = sb.pop_front();
        if (rvalid !== got.v || rdata !== got.d || cyc != got.c) begin
          n_fail++;
          $display("FAIL rvalid_data: got rvalid=%b rdata=%h cycle %0d, required rvalid=%b rdata=%h cycle %0d",
                   rvalid, rdata, cyc, got.v, got.d, got.c);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    mem[14'h0123] = 8'hA5;
    mem[14'h0200] = 8'h11;
    mem[14'h0300] = 8'h22;
    mem[14'h0400] = 8'h44;
    reset = 1'b1;
    req   = 3'b111;
    we    = 3'b000;
    addr  = '0;
    din   = '0;
    repeat (2) @(negedge clk);

    // Reset state; requests present but gnt must stay low.
    #1;
    chk("reset_gnt", 32'(gnt), 32'(3'b000));
    chk("reset_ram_ce", 32'(ram_ce), 32'd0);
    chk("reset_ram_wr", 32'(ram_wr), 32'd0);
    chk("reset_ram_addr", 32'(ram_addr), 32'd0);
    chk("reset_ram_din", 32'(ram_din), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    req   = 3'b000;
    reset = 1'b0;
    @(negedge clk);

    // Single read by requester 1.
    req = 3'b010;
    addr[ADDR +: ADDR] = 14'h0123;
    tick(3'b010, 8'hA5, "rd1_gnt");
    req = 3'b000;
    chk("rd1_ram_ce", 32'(ram_ce), 32'd1);
    chk("rd1_ram_wr", 32'(ram_wr), 32'd0);
    chk("rd1_ram_addr", 32'(ram_addr), 32'h0123);
    idle(3);

    // Write then read-after-write by requester 2.
    req = 3'b100;
    we  = 3'b100;
    addr[2*ADDR +: ADDR] = 14'h0040;
    din[2*DATA +: DATA]  = 8'h3C;
    tick(3'b100, 8'h00, "wr2_gnt");
    we = 3'b000;
    chk("wr2_ram_wr", 32'(ram_wr), 32'd1);
    chk("wr2_ram_din", 32'(ram_din), 32'h3C);
    tick(3'b100, 8'h3C, "raw2_gnt");
    idle(3);

    // Priority and starvation: video held, CPU waits MAX_WAIT cycles.
    req = 3'b011;
    addr[0 +: ADDR]    = 14'h0200;
    addr[ADDR +: ADDR] = 14'h0300;
    for (int k = 0; k < 7; k++) tick(3'b001, 8'h11, "starve_gnt0");
    chk("starve_w1_sat", 32'(dut.w1), 32'd7);
    tick(3'b010, 8'h22, "starve_gnt1");
    req = 3'b001;
    tick(3'b001, 8'h11, "starve_resume0");
    idle(3);

    // Reset mid-read: grant to 1 in T, reset during T+1 (rr would be 2).
    req = 3'b010;
    tick(3'b010, 8'h22, "rst_rd_gnt");
    reset = 1'b1;
    req   = 3'b110;
    sb.delete();
    tick(3'b000, 8'h00, "rst_gnt_low");
    reset = 1'b0;
    req   = 3'b000;
    #1;
    chk("rst_no_rvalid", 32'(rvalid), 32'd0);
    chk("rst_ram_ce", 32'(ram_ce), 32'd0);
    chk("rst_w1", 32'(dut.w1), 32'd0);
    chk("rst_w2", 32'(dut.w2), 32'd0);
    @(negedge clk);
    idle(2);

    // Round-robin between 1 and 2; rr must restart at requester 1.
    req = 3'b110;
    addr[2*ADDR +: ADDR] = 14'h0400;
    for (int k = 0; k < 4; k++) begin
      chk("rr_w1_le1", 32'(dut.w1 <= 4'd1), 32'd1);
      chk("rr_w2_le1", 32'(dut.w2 <= 4'd1), 32'd1);
      if (k % 2 == 0) tick(3'b010, 8'h22, "rr_gnt");
      else            tick(3'b100, 8'h44, "rr_gnt");
    end
    idle(3);

    // Back-to-back reads from 0, 1, 2.
    req = 3'b001;
    tick(3'b001, 8'h11, "mix_gnt0");
    req = 3'b010;
    tick(3'b010, 8'h22, "mix_gnt1");
    req = 3'b100;
    tick(3'b100, 8'h44, "mix_gnt2");
    idle(4);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
